// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a 2:1 mux into a single-entry output register (optional MUX2_ARB_STATS_EN adds grant counters).
// Latency: 1 cycle from accepted input beat to y_valid; throughput one beat per clock.
// Backpressure: a requester is readied only when the output stage is empty or draining this cycle.
module mux2_rr_arbiter #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [W-1:0]     i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [W-1:0]     i1_data,
  output logic             i1_ready,
  output logic             s,
  output logic             y_valid,
  output logic [W-1:0]     y_data,
  output logic             y_src,
`ifdef MUX2_ARB_STATS_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
`endif
  input  logic             y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   y_data_q, y_data_d;
  logic           y_src_q, y_src_d;
  logic           last_gnt_q, last_gnt_d;
  logic           load;
  logic           sel;
  logic           xfer0, xfer1;

  always_comb begin
    load = (state_q == EMPTY) | y_ready;
    sel  = last_gnt_q;
    // On a tie the requester that did not win last goes next; idle keeps priority.
    if (i0_valid && i1_valid) sel = ~last_gnt_q;
    else if (i1_valid)        sel = 1'b1;
    else if (i0_valid)        sel = 1'b0;
    i0_ready = load & ~rst & ~sel & i0_valid;
    i1_ready = load & ~rst &  sel & i1_valid;
    xfer0    = i0_valid & i0_ready;
    xfer1    = i1_valid & i1_ready;
  end

  always_comb begin
    state_d    = state_q;
    y_data_d   = y_data_q;
    y_src_d    = y_src_q;
    last_gnt_d = last_gnt_q;
    if (xfer0 || xfer1) begin
      state_d    = FULL;
      y_data_d   = sel ? i1_data : i0_data;
      y_src_d    = sel;
      last_gnt_d = sel;
    end else if (state_q == FULL && y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      y_data_q   <= '0;
      y_src_q    <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      y_data_q   <= y_data_d;
      y_src_q    <= y_src_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign s       = sel;
  assign y_valid = (state_q == FULL);
  assign y_data  = y_data_q;
  assign y_src   = y_src_q;

`ifdef MUX2_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

  // Counters wrap freely; a clear beats a same-cycle increment.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q + {{(CNT_W-1){1'b0}}, xfer0};
    gnt_cnt1_d = gnt_cnt1_q + {{(CNT_W-1){1'b0}}, xfer1};
    if (cnt_clr) begin
      gnt_cnt0_d = '0;
      gnt_cnt1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux2_rr_arbiter;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i0_valid = 1'b0, i1_valid = 1'b0, y_ready = 1'b0;
  logic [W-1:0] i0_data = '0, i1_data = '0;
  logic         i0_ready, i1_ready, s, y_valid, y_src;
  logic [W-1:0] y_data;
`ifdef MUX2_ARB_STATS_EN
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
  int               m_c0 = 0, m_c1 = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state: who won last, and what the output register holds.
  bit           m_last = 1'b1;
  bit           m_vld  = 1'b0;
  bit           m_src  = 1'b0;
  bit [W-1:0]   m_dat  = '0;
  bit           e_sel, e_r0, e_r1;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
    .s(s), .y_valid(y_valid), .y_data(y_data), .y_src(y_src),
`ifdef MUX2_ARB_STATS_EN
    .cnt_clr(cnt_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
    .y_ready(y_ready)
  );

  task automatic mdl_comb();
    bit can_take;
    can_take = !m_vld || y_ready;
    if (i0_valid && i1_valid) e_sel = !m_last;
    else if (i1_valid)        e_sel = 1'b1;
    else if (i0_valid)        e_sel = 1'b0;
    else                      e_sel = m_last;
    e_r0 = can_take && !rst && i0_valid && (e_sel == 1'b0);
    e_r1 = can_take && !rst && i1_valid && (e_sel == 1'b1);
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic advance();
    mdl_comb();
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_dat = '0; m_src = 0; m_last = 1;
`ifdef MUX2_ARB_STATS_EN
      m_c0 = 0; m_c1 = 0;
`endif
    end else begin
`ifdef MUX2_ARB_STATS_EN
      if (e_r0) m_c0 = (m_c0 + 1) % (1 << CNT_W);
      if (e_r1) m_c1 = (m_c1 + 1) % (1 << CNT_W);
      if (cnt_clr) begin m_c0 = 0; m_c1 = 0; end
`endif
      if (e_r0)                    begin m_vld = 1; m_dat = i0_data; m_src = 0; m_last = 0; end
      else if (e_r1)               begin m_vld = 1; m_dat = i1_data; m_src = 1; m_last = 1; end
      else if (m_vld && y_ready)   m_vld = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; i0_valid = 1; i1_valid = 1; y_ready = 1;
    i0_data = 8'h33; i1_data = 8'h44;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({i0_ready, i1_ready} !== 2'b00) begin
        errors++; $display("FAIL reset_ready got %b required 00", {i0_ready, i1_ready});
      end
      advance();
      checks++;
      if ({y_valid, y_data} !== {1'b0, 8'h00}) begin
        errors++; $display("FAIL reset_y got v=%b d=%h required v=0 d=00", y_valid, y_data);
      end
    end
    rst = 0;
    #1;
    checks++;
    if ({s, i0_ready, i1_ready} !== 3'b010) begin
      errors++; $display("FAIL reset_first_tie got s/r0/r1=%b required 010", {s, i0_ready, i1_ready});
    end
    advance();
    checks++;
    if ({y_valid, y_src} !== 2'b10) begin
      errors++; $display("FAIL reset_first_src got v=%b src=%b required v=1 src=0", y_valid, y_src);
    end
  endtask

  task automatic test_only_i1();
    i0_valid = 0; i1_valid = 1; i1_data = 8'h5A; y_ready = 1;
    #1;
    checks++;
    if ({s, i0_ready, i1_ready} !== 3'b101) begin
      errors++; $display("FAIL only_i1_grant got s/r0/r1=%b required 101", {s, i0_ready, i1_ready});
    end
    advance();
    checks++;
    if ({y_valid, y_src, y_data} !== {1'b1, 1'b1, 8'h5A}) begin
      errors++; $display("FAIL only_i1_out got v=%b src=%b d=%h required v=1 src=1 d=5a", y_valid, y_src, y_data);
    end
  endtask

  task automatic test_alternate();
    bit [W-1:0] exp_d;
    i0_valid = 1; i1_valid = 1; y_ready = 1;
    for (int k = 0; k < 6; k++) begin
      i0_data = 8'h10 + 8'(k);
      i1_data = 8'h20 + 8'(k);
      #1;
      mdl_comb();
      checks++;
      if ({s, i0_ready, i1_ready} !== {e_sel, e_r0, e_r1}) begin
        errors++; $display("FAIL alt_grant k=%0d got %b required %b", k, {s, i0_ready, i1_ready}, {e_sel, e_r0, e_r1});
      end
      advance();
      exp_d = (k % 2 == 1) ? 8'h20 + 8'(k) : 8'h10 + 8'(k);
      checks++;
      if ({y_valid, y_src, y_data} !== {1'b1, 1'(k % 2), exp_d}) begin
        errors++; $display("FAIL alt_out k=%0d got v=%b src=%b d=%h required v=1 src=%0d d=%h", k, y_valid, y_src, y_data, k % 2, exp_d);
      end
    end
  endtask

  task automatic test_hold();
    bit [W-1:0] saved;
    saved = y_data;
    i0_valid = 1; i1_valid = 1; y_ready = 0; i0_data = 8'hA0; i1_data = 8'hB0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({i0_ready, i1_ready} !== 2'b00) begin
        errors++; $display("FAIL hold_ready cyc=%0d got %b required 00", i, {i0_ready, i1_ready});
      end
      advance();
      checks++;
      if ({y_valid, y_data} !== {1'b1, saved}) begin
        errors++; $display("FAIL hold_y cyc=%0d got v=%b d=%h required v=1 d=%h", i, y_valid, y_data, saved);
      end
    end
    y_ready = 1;
    #1;
    mdl_comb();
    checks++;
    if ({s, i0_ready, i1_ready} !== {e_sel, e_r0, e_r1} || !(i0_ready ^ i1_ready)) begin
      errors++; $display("FAIL drain_load_grant got %b required %b", {s, i0_ready, i1_ready}, {e_sel, e_r0, e_r1});
    end
    advance();
    checks++;
    if ({y_valid, y_src, y_data} !== {1'b1, m_src, m_dat}) begin
      errors++; $display("FAIL drain_load_out got v=%b src=%b d=%h required v=1 src=%b d=%h", y_valid, y_src, y_data, m_src, m_dat);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1; y_ready = 0; i0_valid = 1; i1_valid = 1;
    advance();
    checks++;
    if ({y_valid, y_data, y_src} !== {1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL midrst_y got v=%b d=%h src=%b required 0/00/0", y_valid, y_data, y_src);
    end
    rst = 0; y_ready = 1; i0_data = 8'hC1; i1_data = 8'hD2;
    #1;
    checks++;
    if ({s, i0_ready, i1_ready} !== 3'b010) begin
      errors++; $display("FAIL midrst_tie got s/r0/r1=%b required 010", {s, i0_ready, i1_ready});
    end
    advance();
    checks++;
    if ({y_valid, y_src, y_data} !== {1'b1, 1'b0, 8'hC1}) begin
      errors++; $display("FAIL midrst_out got v=%b src=%b d=%h required v=1 src=0 d=c1", y_valid, y_src, y_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      i0_valid = ($urandom_range(0, 3) != 0);
      i1_valid = ($urandom_range(0, 3) != 0);
      y_ready  = ($urandom_range(0, 2) != 0);
      i0_data  = W'($urandom);
      i1_data  = W'($urandom);
`ifdef MUX2_ARB_STATS_EN
      cnt_clr  = ($urandom_range(0, 29) == 0);
`endif
      #1;
      mdl_comb();
      checks++;
      if ({i0_ready, i1_ready} !== {e_r0, e_r1} || (s !== e_sel)) begin
        errors++; $display("FAIL rand_grant n=%0d got s/r0/r1=%b required %b", n, {s, i0_ready, i1_ready}, {e_sel, e_r0, e_r1});
      end
      advance();
      checks++;
      if ({y_valid, y_src, y_data} !== {m_vld, m_src, m_dat}) begin
        errors++; $display("FAIL rand_out n=%0d got v=%b src=%b d=%h required v=%b src=%b d=%h", n, y_valid, y_src, y_data, m_vld, m_src, m_dat);
      end
`ifdef MUX2_ARB_STATS_EN
      checks++;
      if ({gnt_cnt0, gnt_cnt1} !== {CNT_W'(m_c0), CNT_W'(m_c1)}) begin
        errors++; $display("FAIL rand_cnt n=%0d got %0d/%0d required %0d/%0d", n, gnt_cnt0, gnt_cnt1, m_c0, m_c1);
      end
`endif
    end
    rst = 0;
`ifdef MUX2_ARB_STATS_EN
    cnt_clr = 0;
`endif
  endtask

`ifdef MUX2_ARB_STATS_EN
  task automatic test_stats();
    rst = 1; i0_valid = 0; i1_valid = 0; y_ready = 1;
    advance();
    rst = 0; i0_valid = 1;
    for (int k = 0; k < 17; k++) begin
      i0_data = W'(k);
      advance();
    end
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL stats_wrap got %0d/%0d required 1/0", gnt_cnt0, gnt_cnt1);
    end
    cnt_clr = 1;
    #1;
    checks++;
    if (i0_ready !== 1'b1) begin
      errors++; $display("FAIL stats_clr_xfer got i0_ready=%b required 1", i0_ready);
    end
    advance();
    cnt_clr = 0;
    checks++;
    if ({gnt_cnt0, gnt_cnt1, y_valid} !== {4'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL stats_clr got %0d/%0d v=%b required 0/0 v=1", gnt_cnt0, gnt_cnt1, y_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_only_i1();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef MUX2_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
